mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 reset  in  1  reset, asynchronous, active-low.
REQ-003 cpustate  in  2  CPU mode: 2'b00 IN (load), 2'b01 CHECK (readback), 2'b11 RUN, 2'b10 reserved.
REQ-004 mem_read  in  1  CPU read request; level, RUN mode only.
REQ-005 mem_write  in  1  CPU write request; level, RUN mode only.
REQ-006 addr  in  8  CPU address from AR.
REQ-007 wdata  in  8  CPU write data from the bus.
REQ-008 rdata  out  8  read data; valid only while rvalid=1.
REQ-009 rvalid  out  1  one-cycle pulse: read completed.
REQ-010 mem_rdy  out  1  1 while the responder is IDLE and can accept a request.
REQ-011 ld_valid  in  1  IN mode: ld_data is valid this cycle.
REQ-012 ld_data  in  8  IN mode: program byte.
REQ-013 chk_req  in  1  CHECK mode: request the next readback byte.
REQ-014 ptr  out  8  current load/check pointer.
REQ-015 wrap  out  1  sticky: pointer wrapped from 255 to 0.
REQ-016 err  out  1  sticky: illegal request (both mem_read and mem_write, or a request in a non-RUN mode).

Function
REQ-017 Storage SHALL be 256 x 8 bits, addressed by addr or ptr.
REQ-018 The FSM SHALL have the states IDLE, WAIT, RESP.
REQ-019 IDLE SHALL sample the requests. A valid request moves the FSM to WAIT, or directly to RESP when parameter WAIT_CYCLES=0.
REQ-020 WAIT SHALL count WAIT_CYCLES cycles (parameter, 0..7, default 1) and then move to RESP.
REQ-021 RESP SHALL last one cycle and return to IDLE.
REQ-022 Minimum request-to-completion latency SHALL be WAIT_CYCLES+1 cycles.
REQ-023 Writes SHALL commit to the array in the RESP cycle.
REQ-024 For reads, rdata and rvalid SHALL be driven in the RESP cycle.
REQ-025 addr and wdata SHALL be captured in IDLE. Changes during WAIT have no effect.
REQ-026 mem_rdy SHALL equal (state==IDLE). Requests outside IDLE are ignored, not queued.
REQ-027 mem_read and mem_write both high in IDLE: the responder SHALL perform the write only and set err.
REQ-028 In IN mode, each ld_valid cycle SHALL write ld_data to mem[ptr] with zero latency and increment ptr. The FSM stays IDLE.
REQ-029 In CHECK mode, chk_req in IDLE SHALL perform a read of mem[ptr] through WAIT/RESP. ptr SHALL increment in the RESP cycle.
REQ-030 ptr SHALL reset to 0 on any change of cpustate.
REQ-031 ptr increment from 255 SHALL give 0 and set wrap.
REQ-032 mem_read or mem_write in a non-RUN mode SHALL be ignored and SHALL set err.
REQ-033 ld_valid outside IN mode and chk_req outside CHECK mode SHALL be ignored silently.
REQ-034 A cpustate change during WAIT SHALL abort the access: the FSM returns to IDLE, with no write and no rvalid.
REQ-035 In mode 2'b10, the responder SHALL hold IDLE with mem_rdy=1 and perform no accesses.

Reset
REQ-036 Reset SHALL give: state=IDLE, rdata=0, rvalid=0, mem_rdy=1, ptr=0, wrap=0, err=0, wait counter=0.
REQ-037 Array contents SHALL NOT be cleared by reset.
REQ-038 Reset asserted mid-access SHALL abandon the access with no write.

Configuration
REQ-039 With MEM_PARITY_EN defined, each word SHALL store an even-parity bit, generated on every write.
REQ-040 With MEM_PARITY_EN defined, a read with a parity mismatch SHALL pulse perr (out, 1) together with rvalid.
REQ-041 Without MEM_PARITY_EN, the array SHALL be 8 bits wide and perr SHALL be tied to 0.

Structure
REQ-042 A shared package SHALL hold the cpustate encodings (ST_IN, ST_CHECK, ST_RUN), the FSM state enum and the default WAIT_CYCLES.
REQ-043 The storage SHALL be a sub-module mem_array: one synchronous write port and one asynchronous read port.
REQ-044 mem_array width SHALL be 8, or 9 with MEM_PARITY_EN.

Verification
REQ-045 IN mode, ld_valid with bytes 0x11,0x22,0x33 -> mem[0..2]=11,22,33 and ptr=3.
REQ-046 CHECK mode, three chk_req (one per IDLE) -> rvalid pulses with rdata 11,22,33, each WAIT_CYCLES+1 cycles after its request.
REQ-047 RUN mode, WAIT_CYCLES=1: write 0xA5 to addr 0x40, then read 0x40 -> mem_rdy low 2 cycles each, rdata=0xA5 with rvalid.
REQ-048 RUN mode, mem_read and mem_write both high (addr 0x10, wdata 0x5A) -> mem[0x10]=0x5A, no rvalid, err=1.
REQ-049 IN mode, 257 ld_valid bytes -> wrap=1, ptr=1, mem[0] holds the 257th byte.
REQ-050 RUN mode, reset asserted during WAIT of a write of 0xFF to 0x20 -> mem[0x20] unchanged, all outputs at reset values.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice: CPU mode encodings, the
// responder FSM states, captured operation kinds, storage word width and
// the parity helper used when MEM_PARITY_EN is defined.
package mem_responder_pkg;

    // CPU mode encodings on cpustate; 2'b10 is reserved and treated as idle.
    localparam logic [1:0] ST_IN    = 2'b00;
    localparam logic [1:0] ST_CHECK = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b11;

    // Wait states inserted between request acceptance and response.
    localparam int DEFAULT_WAIT_CYCLES = 1;

    // Storage word: data byte, plus an even-parity bit when enabled.
`ifdef MEM_PARITY_EN
    localparam int MEM_W = 9;
`else
    localparam int MEM_W = 8;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Kind of access captured in IDLE and carried through WAIT/RESP.
    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_CHECK
    } op_t;

    // Bit that makes the total number of ones in {parity, data} even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// 256-entry storage for mem_responder: one synchronous write port and one
// asynchronous read port. Word width is 8, or 9 with MEM_PARITY_EN defined
// (set by the instantiating top through parameter W).
module mem_array #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         we,
    input  logic [7:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [7:0]   raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [256];

    // Synchronous write port.
    // NOTE: the array deliberately has no reset; contents must survive reset
    // and a reset branch would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: 256 x 8 memory shared by a CPU in three modes.
//   IN    - ld_valid bytes are written to mem[ptr] with zero latency.
//   CHECK - chk_req reads mem[ptr] through the WAIT/RESP handshake.
//   RUN   - mem_read/mem_write access mem[addr] through WAIT/RESP.
// Optional feature macro: MEM_PARITY_EN adds an even-parity bit per word and
// drives perr on a read whose stored parity does not match; without it perr
// is tied to 0.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cpustate,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       mem_rdy,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       chk_req,
    output logic [7:0] ptr,
    output logic       wrap,
    output logic       err,
    output logic       perr
);

    // Value of the wait counter on the last WAIT cycle.
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t     state, state_nxt;
    logic [2:0] wait_cnt, wait_cnt_nxt;
    logic [1:0] mode_q;
    op_t        cap_op, cap_op_nxt;
    logic [7:0] cap_addr, cap_addr_nxt;
    logic [7:0] cap_wdata, cap_wdata_nxt;
    logic [7:0] ptr_nxt;
    logic       wrap_nxt;
    logic       err_nxt;

    logic       is_idle;
    logic       mode_change;
    logic       in_mode, check_mode, run_mode;
    logic       req_any;
    logic       accept_run, accept_chk, accept;
    logic       load;
    logic       ptr_inc;
    logic [7:0] ptr_base;

    logic             mem_we;
    logic [7:0]       mem_waddr;
    logic [7:0]       wr_byte;
    logic [MEM_W-1:0] mem_wword;
    logic [MEM_W-1:0] mem_rword;

    assign is_idle     = (state == S_IDLE);
    assign mode_change = (cpustate != mode_q);
    assign in_mode     = (cpustate == ST_IN);
    assign check_mode  = (cpustate == ST_CHECK);
    assign run_mode    = (cpustate == ST_RUN);
    assign req_any     = mem_read | mem_write;

    // Requests are only sampled in IDLE; anything arriving later is dropped.
    assign accept_run  = is_idle && run_mode && req_any;
    assign accept_chk  = is_idle && check_mode && chk_req;
    assign accept      = accept_run | accept_chk;
    assign load        = is_idle && in_mode && ld_valid;

    // A mode change zeroes the pointer, so anything using it this cycle
    // already sees the post-change value.
    assign ptr_base    = mode_change ? 8'h00 : ptr;

    // FSM next state, wait counting and capture of the accepted request.
    // NOTE: every signal assigned here gets a default first so no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        cap_op_nxt    = cap_op;
        cap_addr_nxt  = cap_addr;
        cap_wdata_nxt = cap_wdata;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt     = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    wait_cnt_nxt  = 3'd0;
                    cap_addr_nxt  = accept_chk ? ptr_base : addr;
                    cap_wdata_nxt = wdata;
                    if (accept_chk) begin
                        cap_op_nxt = OP_CHECK;
                    end else if (mem_write) begin
                        // Write wins when both requests are raised together.
                        cap_op_nxt = OP_WRITE;
                    end else begin
                        cap_op_nxt = OP_READ;
                    end
                end
            end
            S_WAIT: begin
                if (mode_change) begin
                    // Mode switched mid-access: abandon it without effects.
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = 3'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = S_RESP;
                    wait_cnt_nxt = 3'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = 3'd0;
            end
        endcase
    end

    // Pointer advance, sticky wrap and sticky error flags.
    always_comb begin
        ptr_inc  = load || ((state == S_RESP) && (cap_op == OP_CHECK) && !mode_change);
        ptr_nxt  = ptr_inc ? ptr_base + 8'd1 : ptr_base;
        wrap_nxt = wrap || (ptr_inc && (ptr_base == 8'hFF));
        err_nxt  = err
                   || (req_any && !run_mode)
                   || (accept_run && mem_read && mem_write);
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            mode_q    <= ST_IN;
            cap_op    <= OP_READ;
            cap_addr  <= 8'h00;
            cap_wdata <= 8'h00;
            ptr       <= 8'h00;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mode_q    <= cpustate;
            cap_op    <= cap_op_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_wdata <= cap_wdata_nxt;
            ptr       <= ptr_nxt;
            wrap      <= wrap_nxt;
            err       <= err_nxt;
        end
    end

    // Write port: zero-latency loads in IN mode, RUN writes in RESP; both
    // are blocked while reset is held so an abandoned access never lands.
    always_comb begin
        mem_we    = reset && (load || ((state == S_RESP) && (cap_op == OP_WRITE)));
        mem_waddr = load ? ptr_base : cap_addr;
        wr_byte   = load ? ld_data  : cap_wdata;
`ifdef MEM_PARITY_EN
        mem_wword = {even_parity(wr_byte), wr_byte};
`else
        mem_wword = wr_byte;
`endif
    end

    mem_array #(
        .W (MEM_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wword),
        .raddr (cap_addr),
        .rdata (mem_rword)
    );

    assign mem_rdy = is_idle;
    assign rvalid  = (state == S_RESP) && (cap_op != OP_WRITE);
    assign rdata   = rvalid ? mem_rword[7:0] : 8'h00;

`ifdef MEM_PARITY_EN
    assign perr = rvalid && (mem_rword[8] != even_parity(mem_rword[7:0]));
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with the default WAIT_CYCLES of 1:
// IN-mode loading, CHECK-mode readback, a table of RUN-mode accesses, and
// hand-written sequences for reset mid-access, mode-change abort, the
// reserved mode and pointer wrap.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] cpustate;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       mem_rdy;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       chk_req;
    logic [7:0] ptr;
    logic       wrap;
    logic       err;
    logic       perr;

    int n_tests = 0;
    int n_fail  = 0;

    mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cpustate  (cpustate),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .mem_rdy   (mem_rdy),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .chk_req   (chk_req),
        .ptr       (ptr),
        .wrap      (wrap),
        .err       (err),
        .perr      (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        int         exp_rv;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request for a single cycle (starting just after an edge,
    // responder idle), scramble addr/wdata afterwards, then watch a fixed
    // four-cycle window. Returns to just after an edge.
    task automatic do_req(input logic rd, input logic wr, input logic ck,
                          input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] got_rdata, output int rv_cnt,
                          output int rv_at, output int busy);
        mem_read  = rd;
        mem_write = wr;
        chk_req   = ck;
        addr      = a;
        wdata     = d;
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk_req   = 1'b0;
        addr      = ~a;
        wdata     = ~d;
        got_rdata = 8'h00;
        rv_cnt    = 0;
        rv_at     = -1;
        busy      = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (!mem_rdy) busy++;
            if (rvalid) begin
                rv_cnt++;
                rv_at     = c;
                got_rdata = rdata;
            end
        end
        tick();
    endtask

    task automatic load_bytes(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            ld_valid = 1'b1;
            ld_data  = (i == 256) ? 8'hC3 : 8'(i);
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_rdata"},   32'(rdata),   32'h00);
        check({tag, "_rvalid"},  32'(rvalid),  32'h0);
        check({tag, "_mem_rdy"}, 32'(mem_rdy), 32'h1);
        check({tag, "_ptr"},     32'(ptr),     32'h00);
        check({tag, "_wrap"},    32'(wrap),    32'h0);
        check({tag, "_err"},     32'(err),     32'h0);
        check({tag, "_perr"},    32'(perr),    32'h0);
    endtask

    initial begin
        logic [7:0] got;
        int         rv_cnt, rv_at, busy;
        logic [7:0] chk_exp [3];

        vecs[0] = '{1'b0, 1'b1, 8'h40, 8'hA5, 0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h40, 8'h00, 1, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h30, 8'h12, 0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h20, 8'h77, 0, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h3C, 0, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1, 8'h3C, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'h30, 8'h00, 1, 8'h12, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h01, 8'h00, 1, 8'h22, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 8'h10, 8'h5A, 0, 8'h00, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 8'h10, 8'h00, 1, 8'h5A, 1'b1};
        chk_exp = '{8'h11, 8'h22, 8'h33};

        reset     = 1'b0;
        cpustate  = ST_IN;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 8'h00;
        wdata     = 8'h00;
        ld_valid  = 1'b0;
        ld_data   = 8'h00;
        chk_req   = 1'b0;

        // Reset values.
        #3;
        check_outputs_reset("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // IN mode: three bytes, zero latency, FSM stays idle.
        ld_valid = 1'b1;
        ld_data  = 8'h11;
        @(negedge clk);
        check("in_mem_rdy", 32'(mem_rdy), 32'h1);
        tick();
        ld_data = 8'h22;
        tick();
        ld_data = 8'h33;
        tick();
        ld_valid = 1'b0;
        chk_req  = 1'b1;     // ignored silently outside CHECK mode
        tick();
        chk_req = 1'b0;
        @(negedge clk);
        check("in_ptr", 32'(ptr), 32'h03);
        check("in_chk_ignored_rdy", 32'(mem_rdy), 32'h1);
        check("in_chk_ignored_err", 32'(err), 32'h0);

        // CHECK mode: pointer restarts at 0, three readbacks.
        tick();
        cpustate = ST_CHECK;
        tick();
        @(negedge clk);
        check("chk_ptr_reset", 32'(ptr), 32'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, got, rv_cnt, rv_at, busy);
            check($sformatf("chk%0d_rvalid_cnt", i), 32'(rv_cnt), 32'd1);
            check($sformatf("chk%0d_latency", i), 32'(rv_at), 32'd2);
            check($sformatf("chk%0d_rdata", i), 32'(got), 32'(chk_exp[i]));
            check($sformatf("chk%0d_ptr", i), 32'(ptr), 32'(i + 1));
        end

        // RUN mode: table of accesses.
        cpustate = ST_RUN;
        tick();
        @(negedge clk);
        check("run_ptr_reset", 32'(ptr), 32'h00);
        tick();
        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].a, vecs[i].d, got, rv_cnt, rv_at, busy);
            check($sformatf("vec%0d_rvalid_cnt", i), 32'(rv_cnt), 32'(vecs[i].exp_rv));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd2);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].exp_rv != 0) begin
                check($sformatf("vec%0d_rdata", i), 32'(got), 32'(vecs[i].exp_rdata));
                check($sformatf("vec%0d_latency", i), 32'(rv_at), 32'd2);
                check($sformatf("vec%0d_perr", i), 32'(perr), 32'h0);
            end
        end

        // Reset asserted during WAIT of a write: no write, reset outputs.
        mem_write = 1'b1;
        addr      = 8'h20;
        wdata     = 8'hFF;
        tick();
        mem_write = 1'b0;
        @(negedge clk);
        check("rstwait_in_wait", 32'(mem_rdy), 32'h0);
        reset = 1'b0;
        #1;
        check_outputs_reset("rstwait");
        tick();
        tick();
        reset = 1'b1;
        tick();
        do_req(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, got, rv_cnt, rv_at, busy);
        check("rstwait_rb_rdata", 32'(got), 32'h77);
        check("rstwait_rb_rvalid_cnt", 32'(rv_cnt), 32'd1);

        // Mode change during WAIT aborts the write.
        mem_write = 1'b1;
        addr      = 8'h30;
        wdata     = 8'hEE;
        tick();
        mem_write = 1'b0;
        cpustate  = ST_CHECK;
        @(negedge clk);
        check("abort_in_wait", 32'(mem_rdy), 32'h0);
        tick();
        @(negedge clk);
        check("abort_idle", 32'(mem_rdy), 32'h1);
        check("abort_rvalid", 32'(rvalid), 32'h0);
        cpustate = ST_RUN;
        tick();
        do_req(1'b1, 1'b0, 1'b0, 8'h30, 8'h00, got, rv_cnt, rv_at, busy);
        check("abort_rb_rdata", 32'(got), 32'h12);
        check("abort_err", 32'(err), 32'h0);

        // Reserved mode: stays idle, ignores loads, request sets err.
        cpustate = 2'b10;
        tick();
        mem_read = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h99;
        tick();
        mem_read = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        check("rsvd_rdy", 32'(mem_rdy), 32'h1);
        check("rsvd_rvalid", 32'(rvalid), 32'h0);
        check("rsvd_ptr", 32'(ptr), 32'h00);
        check("rsvd_err", 32'(err), 32'h1);
        tick();

        // Pointer wrap: 257 loads in IN mode.
        cpustate = ST_IN;
        tick();
        load_bytes(0, 255);
        @(negedge clk);
        check("wrap_ptr_255", 32'(ptr), 32'hFF);
        check("wrap_before", 32'(wrap), 32'h0);
        tick();
        load_bytes(255, 2);
        @(negedge clk);
        check("wrap_ptr", 32'(ptr), 32'h01);
        check("wrap_set", 32'(wrap), 32'h1);
        tick();
        cpustate = ST_CHECK;
        tick();
        tick();
        do_req(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, got, rv_cnt, rv_at, busy);
        check("wrap_mem0", 32'(got), 32'hC3);
        do_req(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, got, rv_cnt, rv_at, busy);
        check("wrap_mem1", 32'(got), 32'h01);
        check("wrap_sticky", 32'(wrap), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
